// File: rtl/issuer_pkg.sv
// Shared constants for the instruction issuer: opcodes, FSM encoding and
// instruction field positions.
package issuer_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int IMM_FLAG_BIT = 12;
  localparam int RX_MSB = 11;
  localparam int RX_LSB = 9;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  localparam int RY_MSB = 2;
  localparam int RY_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HALT  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  function automatic logic [2:0] get_opcode(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_issuer_prog_mem.sv
// Program memory: one write port plus a registered read port (data valid the
// cycle after the address is presented). The array itself is never reset.
module prog_mem #(
  parameter int AW = 5
) (
  input  logic          i_clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [15:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [15:0]   o_rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_issuer.sv
// Issues one program word at a time to the processor controller, holding Run
// until Done, and stops on HALT, end of memory, or a Done timeout.
module instr_issuer
  import issuer_pkg::*;
#(
  parameter int AW      = 5,
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic          clock,
  input  logic          Rest,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          Done,
  output logic [15:0]   instruction,
  output logic          Run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          err_timeout,
  output logic [CW-1:0] issued_count
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_instr;
  logic          r_run;
  logic [AW-1:0] r_pc;
  logic          r_busy;
  logic          r_halted;
  logic          r_err;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_wait;

  logic          w_stopped;
  logic          w_last;
  logic          w_we;
  logic [AW-1:0] w_rd_addr;
  logic [15:0]   w_rdata;
  logic          w_is_halt;

  assign w_stopped = (r_state == ST_IDLE) || (r_state == ST_HALT) ||
                     (r_state == ST_ERROR);
  assign w_last    = &r_pc;
  assign w_we      = prog_we && w_stopped;
  assign w_is_halt = (get_opcode(w_rdata) == OP_HALT);

  // The read address looks one cycle ahead so the word for the new pc is
  // already registered by the time the FSM sits in its single FETCH cycle.
  always_comb begin
    w_rd_addr = r_pc;
    if (w_stopped && start) begin
      w_rd_addr = '0;
    end else if ((r_state == ST_ISSUE) && Done && !w_last) begin
      w_rd_addr = r_pc + AW'(1);
    end
  end

  prog_mem #(
    .AW(AW)
  ) u_prog_mem (
    .i_clock (clock),
    .i_we    (w_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock) begin
    if (!Rest) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HALT, ST_ERROR: begin
        if (start) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = w_is_halt ? ST_HALT : ST_ISSUE;
      end
      ST_ISSUE: begin
        // Done takes priority over a timeout landing in the same cycle.
        if (Done) begin
          w_state_nxt = w_last ? ST_HALT : ST_FETCH;
        end else if (r_wait == WAIT_LIMIT) begin
          w_state_nxt = ST_ERROR;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status outputs are registered copies of the next-state decode.
  always_ff @(posedge clock) begin
    if (!Rest) begin
      r_run    <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_run    <= (w_state_nxt == ST_ISSUE);
      r_busy   <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_ISSUE);
      r_halted <= (w_state_nxt == ST_HALT);
      r_err    <= (w_state_nxt == ST_ERROR);
    end
  end

  always_ff @(posedge clock) begin
    if (!Rest) begin
      r_instr <= '0;
      r_pc    <= '0;
      r_count <= '0;
      r_wait  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT, ST_ERROR: begin
          if (start) begin
            r_pc    <= '0;
            r_count <= '0;
          end
        end
        ST_FETCH: begin
          if (!w_is_halt) begin
            r_instr <= w_rdata;
            r_wait  <= '0;
          end
        end
        ST_ISSUE: begin
          if (Done) begin
            if (!(&r_count)) begin
              r_count <= r_count + CW'(1);
            end
            if (!w_last) begin
              r_pc <= r_pc + AW'(1);
            end
          end else if (r_wait != WAIT_LIMIT) begin
            r_wait <= r_wait + TW'(1);
          end
        end
        default: begin
          r_wait <= '0;
        end
      endcase
    end
  end

  assign instruction  = r_instr;
  assign Run          = r_run;
  assign pc           = r_pc;
  assign busy         = r_busy;
  assign halted       = r_halted;
  assign err_timeout  = r_err;
  assign issued_count = r_count;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a default instance (AW=5, TIMEOUT=16) and
// a small AW=2 instance for the end-of-memory case.
module tb_instr_issuer;

  logic        clock;
  logic        Rest;
  logic        start;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic        Done;
  logic [15:0] instruction;
  logic        Run;
  logic [4:0]  pc;
  logic        busy;
  logic        halted;
  logic        err_timeout;
  logic [15:0] issued_count;

  logic        start2;
  logic        prog_we2;
  logic [1:0]  prog_addr2;
  logic [15:0] prog_data2;
  logic        Done2;
  logic [15:0] instruction2;
  logic        Run2;
  logic [1:0]  pc2;
  logic        busy2;
  logic        halted2;
  logic        err_timeout2;
  logic [15:0] issued_count2;

  int checks = 0;
  int errors = 0;

  instr_issuer #(.AW(5), .TIMEOUT(16), .CW(16)) dut (
    .clock        (clock),
    .Rest         (Rest),
    .start        (start),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .Done         (Done),
    .instruction  (instruction),
    .Run          (Run),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .err_timeout  (err_timeout),
    .issued_count (issued_count)
  );

  instr_issuer #(.AW(2), .TIMEOUT(16), .CW(16)) dut2 (
    .clock        (clock),
    .Rest         (Rest),
    .start        (start2),
    .prog_we      (prog_we2),
    .prog_addr    (prog_addr2),
    .prog_data    (prog_data2),
    .Done         (Done2),
    .instruction  (instruction2),
    .Run          (Run2),
    .pc           (pc2),
    .busy         (busy2),
    .halted       (halted2),
    .err_timeout  (err_timeout2),
    .issued_count (issued_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [4:0] addr, input logic [15:0] data);
    prog_we = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered just after the edge that moved into ISSUE; holds Done off for
  // 'wait_cycles' ISSUE cycles, then pulses it and ends in the FETCH cycle.
  task automatic run_instr(input string tag, input logic [15:0] exp_instr, input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      chk({tag, "_run"}, Run, 1'b1);
      chk({tag, "_instr"}, instruction, exp_instr);
      tick();
    end
    chk({tag, "_run_last"}, Run, 1'b1);
    chk({tag, "_instr_last"}, instruction, exp_instr);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk({tag, "_gap_run"}, Run, 1'b0);
  endtask

  initial begin
    int n;
    int runs;
    logic seen_nz;
    logic wrapped;

    Rest = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; Done = 1'b0;
    start2 = 1'b0; prog_we2 = 1'b0; prog_addr2 = '0; prog_data2 = '0; Done2 = 1'b0;
    tick();
    tick();
    Rest = 1'b1;

    chk("rst_run", Run, 1'b0);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_pc", pc, 5'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_count", issued_count, 16'd0);

    // mv R1,#5 then HALT
    load(5'd0, 16'h1205);
    load(5'd1, 16'hE000);
    pulse_start();
    chk("t1_fetch_busy", busy, 1'b1);
    chk("t1_fetch_run", Run, 1'b0);
    tick();
    run_instr("t1", 16'h1205, 1);
    tick();
    chk("t1_halted", halted, 1'b1);
    chk("t1_count", issued_count, 16'd1);
    chk("t1_pc", pc, 5'd1);
    chk("t1_halt_run", Run, 1'b0);
    chk("t1_halt_busy", busy, 1'b0);
    chk("t1_halt_instr", instruction, 16'h1205);

    // add, sub, HALT with a slow controller
    load(5'd0, 16'h5203);
    load(5'd1, 16'h7203);
    load(5'd2, 16'hE000);
    pulse_start();
    chk("t2_halt_clr", halted, 1'b0);
    tick();
    run_instr("t2a", 16'h5203, 3);
    tick();
    run_instr("t2b", 16'h7203, 3);
    tick();
    chk("t2_halted", halted, 1'b1);
    chk("t2_count", issued_count, 16'd2);
    chk("t2_pc", pc, 5'd2);

    // Done never arrives
    pulse_start();
    tick();
    n = 0;
    while (Run && n < 40) begin
      n++;
      tick();
    end
    chk("t3_issue_cycles", n, 16);
    chk("t3_err", err_timeout, 1'b1);
    chk("t3_run", Run, 1'b0);
    chk("t3_busy", busy, 1'b0);
    pulse_start();
    chk("t3_err_clr", err_timeout, 1'b0);
    chk("t3_pc", pc, 5'd0);
    chk("t3_count", issued_count, 16'd0);
    tick();
    chk("t3_reissue_run", Run, 1'b1);
    chk("t3_reissue_instr", instruction, 16'h5203);

    // reset while in ISSUE
    Rest = 1'b0;
    tick();
    Rest = 1'b1;
    chk("t5_run", Run, 1'b0);
    chk("t5_instr", instruction, 16'h0000);
    chk("t5_pc", pc, 5'd0);
    chk("t5_count", issued_count, 16'd0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_err", err_timeout, 1'b0);

    // Done in IDLE is ignored
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_idle_run", Run, 1'b0);
    chk("t6_idle_count", issued_count, 16'd0);
    pulse_start();
    tick();
    chk("t5_retained", instruction, 16'h5203);

    // start and prog_we during ISSUE are ignored
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'hE000; start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    chk("t6_issue_run", Run, 1'b1);
    chk("t6_issue_busy", busy, 1'b1);
    chk("t6_issue_pc", pc, 5'd0);
    chk("t6_issue_instr", instruction, 16'h5203);
    run_instr("t6a", 16'h5203, 0);
    chk("t6_pc1", pc, 5'd1);
    tick();
    run_instr("t6b", 16'h7203, 0);
    tick();
    chk("t6_halted", halted, 1'b1);
    chk("t6_count", issued_count, 16'd2);

    // AW=2: end of memory without wrap
    for (int i = 0; i < 4; i++) begin
      prog_we2 = 1'b1;
      prog_addr2 = 2'(i);
      prog_data2 = 16'h1201 + 16'(i);
      tick();
    end
    prog_we2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    Done2 = 1'b1;
    runs = 0;
    seen_nz = 1'b0;
    wrapped = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pc2 != 2'd0) seen_nz = 1'b1;
      if (seen_nz && pc2 == 2'd0) wrapped = 1'b1;
      if (Run2) runs++;
      if (halted2) break;
      tick();
    end
    Done2 = 1'b0;
    chk("t4_halted", halted2, 1'b1);
    chk("t4_pc", pc2, 2'd3);
    chk("t4_count", issued_count2, 16'd4);
    chk("t4_wrapped", wrapped, 1'b0);
    chk("t4_runs", runs, 4);
    chk("t4_busy", busy2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
